dlx_data_mem: RTL and testbench

Data-memory responder for the DLX execute/memory stage. It accepts one load or store request at a time from the processor's memory-access port. It performs big-endian byte, halfword or word accesses against an internal word-organised RAM after a configurable number of wait states. It returns sign- or zero-extended load data, or an error flag for misaligned or out-of-range addresses, through a single-cycle response pulse.

---
 rtl/dlx_data_mem_if.sv | 21 ++
 rtl/dlx_data_mem.sv | 93 +++++++++
 tb/tb_dlx_data_mem.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dlx_data_mem_if.sv
// dlx_data_mem_if: processor memory-access request/response bus
interface dlx_data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dlx_data_mem.sv
// dlx_data_mem: big-endian byte/half/word data memory responder with wait states
module dlx_data_mem #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input logic           clk,
  input logic           rst,
  dlx_data_mem_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  localparam logic [3:0] CNT_INIT = WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
  state_e              state_q;
  logic [3:0]          cnt_q;
  logic                we_q, uns_q, err_q, ready_q, valid_q, resp_err_q;
  logic [1:0]          size_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q, rdata_q;
  logic [31:0]         mem_q [2**ADDR_W];
  logic                idle, accept, commit, in_err, c_we, c_uns, c_err;
  logic [1:0]          c_size, off;
  logic [ADDR_W+1:0]   c_addr;
  logic [ADDR_W-1:0]   idx;
  logic [31:0]         c_wdata, word, mask, ext, wr_word;
  logic [15:0]         lane;
  logic [4:0]          sh;
  // In IDLE the live request is used so a zero-wait access commits on its accept edge
  always_comb begin
    idle    = state_q == IDLE;
    accept  = idle && bus.req_valid;
    in_err  = bus.req_size == 2'b11 || (bus.req_size == 2'b01 && bus.req_addr[0]) ||
              (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) ||
              (bus.req_addr >> (ADDR_W + 2)) != 32'd0;
    c_we    = idle ? bus.req_we : we_q;
    c_uns   = idle ? bus.req_unsigned : uns_q;
    c_size  = idle ? bus.req_size : size_q;
    c_addr  = idle ? bus.req_addr[ADDR_W+1:0] : addr_q;
    c_wdata = idle ? bus.req_wdata : wdata_q;
    c_err   = idle ? in_err : err_q;
    commit  = (accept && WAIT_CYCLES == 0) || (state_q == WAIT && cnt_q == 4'd0);
    idx     = c_addr[ADDR_W+1:2];
    off     = c_addr[1:0];
    word    = mem_q[idx];
    sh      = c_size == 2'b00 ? {~off, 3'b000} : c_size == 2'b01 ? {~off[1], 4'b0000} : 5'd0;
    mask    = c_size == 2'b00 ? 32'hFF << sh : c_size == 2'b01 ? 32'hFFFF << sh : 32'hFFFF_FFFF;
    lane    = 16'(word >> sh);
    ext     = c_size == 2'b00 ? {{24{~c_uns & lane[7]}}, lane[7:0]} :
              c_size == 2'b01 ? {{16{~c_uns & lane[15]}}, lane} : word;
    wr_word = (word & ~mask) | ((c_wdata << sh) & mask);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      resp_err_q <= 1'b0;
      rdata_q    <= 32'd0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
    end else begin
      valid_q    <= commit;
      resp_err_q <= commit && c_err;
      rdata_q    <= commit && !c_err && !c_we ? ext : 32'd0;
      if (accept) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        size_q  <= bus.req_size;
        addr_q  <= bus.req_addr[ADDR_W+1:0];
        wdata_q <= bus.req_wdata;
        err_q   <= in_err;
        cnt_q   <= CNT_INIT;
        ready_q <= 1'b0;
        state_q <= WAIT_CYCLES == 0 ? RESP : WAIT;
      end else if (state_q == WAIT) begin
        state_q <= cnt_q == 4'd0 ? RESP : WAIT;
        cnt_q   <= cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
      end else if (state_q == RESP) begin
        state_q <= IDLE;
        ready_q <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    if (!rst && commit && c_we && !c_err) mem_q[idx] <= wr_word;
  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_dlx_data_mem.sv
// tb_dlx_data_mem: four responders (wait states 1, 0, 15, 3) checked against a byte-array model
module tb_dlx_data_mem;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  int          sel = 0;
  logic [3:0]  ready_v, rv_v, err_v;
  logic [31:0] rd_v [4];
  int          checks = 0, errors = 0;
  logic [7:0]  mdl [4][4096];
  bit          known [4][4096];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    dlx_data_mem_if bus();
    assign bus.req_valid    = req_valid && sel == g;
    assign bus.req_we       = req_we;
    assign bus.req_size     = req_size;
    assign bus.req_unsigned = req_unsigned;
    assign bus.req_addr     = req_addr;
    assign bus.req_wdata    = req_wdata;
    dlx_data_mem #(.ADDR_W(10), .WAIT_CYCLES(g == 0 ? 1 : g == 1 ? 0 : g == 2 ? 15 : 3)) u_dut (
      .clk(clk), .rst(rst), .bus(bus.slave));
    assign ready_v[g] = bus.req_ready;
    assign rv_v[g]    = bus.resp_valid;
    assign err_v[g]   = bus.resp_err;
    assign rd_v[g]    = bus.resp_rdata;
  end
  function automatic int wc_of(input int k);
    return k == 0 ? 1 : k == 1 ? 0 : k == 2 ? 15 : 3;
  endfunction
  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic xact(input int k, input logic we, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    int n, nb, b;
    bit e, kn;
    logic [31:0] exp;
    e  = sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || a >= 32'd4096;
    nb = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    b  = e ? 0 : int'(a);
    exp = 32'd0;
    kn  = 1'b1;
    if (!e && !we) begin
      for (int i = 0; i < nb; i++) begin
        exp = {exp[23:0], mdl[k][b+i]};
        kn &= known[k][b+i];
      end
      if (!u && nb == 1) exp = {{24{exp[7]}}, exp[7:0]};
      if (!u && nb == 2) exp = {{16{exp[15]}}, exp[15:0]};
    end
    @(negedge clk);
    sel = k; req_we = we; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    check("ready_idle", 32'(ready_v[k]), 32'd1);
    @(posedge clk);
    #1;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = 32'($urandom_range(0, 255)); req_wdata = $urandom;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (rv_v[k]) break;
    end
    check("latency", 32'(n), 32'(wc_of(k) + 1));
    check("resp_err", 32'(err_v[k]), 32'(e));
    if (kn) check("resp_rdata", rd_v[k], exp);
    check("ready_in_resp", 32'(ready_v[k]), 32'd0);
    rd = rd_v[k];
    req_valid = 1'b0;
    @(negedge clk);
    check("ready_after_resp", 32'(ready_v[k]), 32'd1);
    check("single_pulse", 32'(rv_v[k]), 32'd0);
    if (we && !e)
      for (int i = 0; i < nb; i++) begin
        mdl[k][b+i]   = wd[8*(nb-1-i) +: 8];
        known[k][b+i] = 1'b1;
      end
  endtask
  task automatic rand_xact(input int k);
    logic [31:0] a, rd;
    a = $urandom_range(0, 9) == 0 ? $urandom : 32'($urandom_range(0, 255));
    xact(k, 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, rd);
  endtask
  initial begin
    logic [31:0] rd;
    bit seen;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("rst_ready", 32'(ready_v[k]), 32'd1);
      check("rst_valid", 32'(rv_v[k]), 32'd0);
      check("rst_err", 32'(err_v[k]), 32'd0);
      check("rst_rdata", rd_v[k], 32'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 64; w++) xact(k, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, rd);
    xact(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd);
    xact(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd);
    check("plan_word", rd, 32'hDEADBEEF);
    xact(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, rd);
    xact(0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA, rd);
    xact(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, rd);
    check("plan_byte_lane", rd, 32'h11AA3344);
    xact(0, 1'b0, 2'd0, 1'b0, 32'h21, 32'd0, rd);
    check("plan_byte_signed", rd, 32'hFFFFFFAA);
    xact(0, 1'b0, 2'd0, 1'b1, 32'h21, 32'd0, rd);
    check("plan_byte_unsigned", rd, 32'h000000AA);
    xact(0, 1'b1, 2'd2, 1'b0, 32'h30, 32'h55667788, rd);
    xact(0, 1'b1, 2'd1, 1'b0, 32'h32, 32'h00008001, rd);
    xact(0, 1'b0, 2'd1, 1'b0, 32'h32, 32'd0, rd);
    check("plan_half_signed", rd, 32'hFFFF8001);
    xact(0, 1'b0, 2'd1, 1'b1, 32'h32, 32'd0, rd);
    check("plan_half_unsigned", rd, 32'h00008001);
    xact(0, 1'b0, 2'd2, 1'b0, 32'h30, 32'd0, rd);
    check("plan_half_word", rd, 32'h55668001);
    xact(0, 1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D, rd);
    xact(0, 1'b0, 2'd2, 1'b0, 32'h13, 32'd0, rd);
    xact(0, 1'b1, 2'd1, 1'b0, 32'h41, 32'h0000BEEF, rd);
    xact(0, 1'b1, 2'd3, 1'b0, 32'h40, 32'h01020304, rd);
    xact(0, 1'b1, 2'd2, 1'b0, 32'h00001000, 32'h0BADF00D, rd);
    xact(0, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0, rd);
    check("plan_err_ram_intact", rd, 32'hCAFEF00D);
    xact(1, 1'b1, 2'd2, 1'b0, 32'h60, 32'hA5A5C3C3, rd);
    xact(1, 1'b0, 2'd0, 1'b0, 32'h63, 32'd0, rd);
    check("wc0_byte", rd, 32'hFFFFFFC3);
    xact(2, 1'b1, 2'd2, 1'b0, 32'h80, 32'h0F1E2D3C, rd);
    xact(2, 1'b0, 2'd1, 1'b1, 32'h80, 32'd0, rd);
    check("wc15_half", rd, 32'h00000F1E);
    xact(2, 1'b0, 2'd1, 1'b0, 32'h81, 32'd0, rd);
    xact(3, 1'b1, 2'd2, 1'b0, 32'h50, 32'd0, rd);
    @(negedge clk);
    sel = 3; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h50; req_wdata = 32'h12345678; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; sel = 0; req_valid = 1'b1; req_addr = 32'h44; req_wdata = $urandom;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    check("abort_ready", 32'(ready_v[3]), 32'd1);
    seen = 1'b0;
    repeat (20) begin
      seen |= rv_v != 4'd0;
      @(negedge clk);
    end
    check("abort_no_resp", 32'(seen), 32'd0);
    xact(3, 1'b0, 2'd2, 1'b0, 32'h50, 32'd0, rd);
    check("abort_not_written", rd, 32'd0);
    xact(0, 1'b0, 2'd2, 1'b0, 32'h44, 32'd0, rd);
    for (int i = 0; i < 120; i++) rand_xact(0);
    for (int i = 0; i < 120; i++) rand_xact(1);
    for (int i = 0; i < 8; i++) rand_xact(2);
    for (int i = 0; i < 20; i++) rand_xact(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
